big_fb_ctrl: RTL and testbench
==============================

BIG_FB_CTRL -- requirements
Module: big_fb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: framebuffer address width; the framebuffer depth is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 6: pixel word width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports fill_start, input, 1 (fill request pulse) and fill_data, input, DATA_W (fill value).
REQ-006 SHALL have ports fill_busy, output, 1 and fill_done, output, 1 (one-cycle completion pulse).
REQ-007 SHALL have write requester A ports: a_req in 1, a_addr in ADDR_W, a_data in DATA_W, a_gnt out 1.
REQ-008 SHALL have write requester B ports: b_req in 1, b_addr in ADDR_W, b_data in DATA_W, b_gnt out 1.
REQ-009 SHALL have RAM write ports: fb_wr_en out 1, fb_wr_addr out ADDR_W, fb_wr_data out DATA_W.
REQ-010 SHALL have display read ports: disp_valid in 1, disp_addr in ADDR_W.
REQ-011 SHALL have host read ports: host_rd_req in 1, host_rd_addr in ADDR_W, host_rd_gnt out 1, host_rd_valid out 1, host_rd_data out DATA_W.
REQ-012 SHALL have RAM read ports: fb_rd_addr out ADDR_W, fb_rd_data in DATA_W; the RAM returns data one cycle after the address is presented.

Function
REQ-013 SHALL implement a two-state FSM: ARB (arbitrate requesters) and FILL (clear engine).
REQ-014 In ARB, fill_start=1 SHALL latch fill_data, clear the fill counter, and enter FILL on the next cycle; no grant is issued in that cycle.
REQ-015 In FILL, each cycle SHALL issue one write of the latched value at the counter address, then increment the counter.
REQ-016 After the write to address 2**ADDR_W-1, the block SHALL return to ARB and pulse fill_done for exactly one cycle; the counter SHALL wrap to 0.
REQ-017 fill_busy SHALL be 1 in every FILL cycle and 0 otherwise; fill_start SHALL be ignored while in FILL.
REQ-018 In ARB, the grant output (a_gnt or b_gnt) SHALL be asserted combinationally in the same cycle as the winning req; at most one grant SHALL be asserted per cycle.
REQ-019 When both a_req and b_req are asserted, the grant SHALL go to the requester not granted most recently (round-robin); when one requests alone, it SHALL win.
REQ-020 The registered write outputs (fb_wr_en=1, addr, data) SHALL appear one cycle after the grant, carrying the granted requester's addr and data as sampled in the grant cycle.
REQ-021 A requester SHALL hold req, addr, and data stable until gnt=1; in FILL, a_gnt and b_gnt SHALL be 0.
REQ-022 fb_wr_en SHALL be 0 in any cycle following a cycle with no grant and no fill write.
REQ-023 The read port SHALL be muxed combinationally: fb_rd_addr = disp_addr when disp_valid=1, else host_rd_addr.
REQ-024 host_rd_gnt SHALL equal host_rd_req & ~disp_valid; the display always has priority.
REQ-025 For a host grant in cycle N, host_rd_data SHALL hold fb_rd_data registered at the end of cycle N+1, and host_rd_valid SHALL be 1 for exactly cycle N+2.
REQ-026 Read-during-write to the same address SHALL return whatever the RAM returns; the block SHALL perform no forwarding.

Reset
REQ-027 While rst=1, the FSM SHALL be in ARB, the counter SHALL be 0, and the round-robin pointer SHALL be "B last", so A wins the first contention.
REQ-028 While rst=1, fill_busy, fill_done, a_gnt, b_gnt, fb_wr_en, host_rd_gnt, and host_rd_valid SHALL be 0, and fb_wr_addr, fb_wr_data, and host_rd_data SHALL be 0.
REQ-029 Reset asserted during FILL SHALL abort the fill with no fill_done pulse, and pending host reads SHALL be discarded.

Verification
REQ-030 Contention: a_req=b_req=1 held for 4 cycles after reset -> grants A,B,A,B; fb_wr_en=1 with the matching addr/data one cycle after each grant.
REQ-031 Fill: fill_start with fill_data=6'h2A -> fill_busy for 2048 cycles; addresses 0..2047 written with 2A; fill_done pulses the cycle after the last write; a_req held throughout is first granted on the cycle after fill_busy falls.
REQ-032 Simultaneous: fill_start=1 with a_req=1 in the same cycle -> a_gnt=0 and FILL entered.
REQ-033 Host read: write 6'h15 to address 0x123, then a host read of 0x123 with disp_valid=0 -> host_rd_valid=1 exactly two cycles after grant, with host_rd_data=15.
REQ-034 Display priority: host_rd_req=1 with disp_valid=1 for 3 cycles -> host_rd_gnt=0 and fb_rd_addr=disp_addr; the grant is issued in the cycle disp_valid drops.
REQ-035 Reset mid-fill: rst asserted at counter=100 -> fill_busy=0 and no fill_done; a new fill_start then restarts the fill from address 0.

Source files
------------

// File: rtl/big_fb_ctrl.sv
// Framebuffer controller: round-robin write arbitration between two requesters,
// a full-depth fill engine, and a display-priority read mux with host read return.
module big_fb_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [DATA_W-1:0] fb_wr_data,
    input  logic              disp_valid,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_gnt,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [DATA_W-1:0] fb_rd_data
);

    typedef enum logic {ARB, FILL} state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic              last_b_q, last_b_d;
    logic              done_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              rd_pend_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_val_d = fill_val_q;
        last_b_d   = last_b_q;
        done_d     = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = cnt_q;
        wr_data_d  = fill_val_q;
        fill_busy  = (state_q == FILL) && !rst;
        if (!rst) begin
            case (state_q)
                ARB: begin
                    if (fill_start) begin
                        fill_val_d = fill_data;
                        cnt_d      = '0;
                        state_d    = FILL;
                    end else if (a_req && (!b_req || last_b_q)) begin
                        a_gnt     = 1'b1;
                        last_b_d  = 1'b0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = a_addr;
                        wr_data_d = a_data;
                    end else if (b_req) begin
                        b_gnt     = 1'b1;
                        last_b_d  = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = b_addr;
                        wr_data_d = b_data;
                    end
                end
                FILL: begin
                    wr_en_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_d = ARB;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // Display always owns the read port; the host only sees a grant when it is idle.
    always_comb begin
        fb_rd_addr  = disp_valid ? disp_addr : host_rd_addr;
        host_rd_gnt = host_rd_req && !disp_valid && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB;
            cnt_q         <= '0;
            fill_val_q    <= '0;
            last_b_q      <= 1'b1;
            fill_done     <= 1'b0;
            fb_wr_en      <= 1'b0;
            fb_wr_addr    <= '0;
            fb_wr_data    <= '0;
            rd_pend_q     <= 1'b0;
            host_rd_valid <= 1'b0;
            host_rd_data  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_val_q <= fill_val_d;
            last_b_q   <= last_b_d;
            fill_done  <= done_d;
            fb_wr_en   <= wr_en_d;
            if (wr_en_d) begin
                fb_wr_addr <= wr_addr_d;
                fb_wr_data <= wr_data_d;
            end
            // RAM data for a grant in cycle N arrives in N+1 and is presented in N+2.
            rd_pend_q     <= host_rd_gnt;
            host_rd_valid <= rd_pend_q;
            if (rd_pend_q) host_rd_data <= fb_rd_data;
        end
    end

endmodule

// File: tb/tb_big_fb_ctrl.sv
// Directed bench for big_fb_ctrl: a vector table for arbitration plus
// hand-written fill, host-read, display-priority and reset sequences.
module tb_big_fb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_start;
    logic [5:0]  fill_data;
    logic        fill_busy, fill_done;
    logic        a_req, b_req, a_gnt, b_gnt;
    logic [10:0] a_addr, b_addr;
    logic [5:0]  a_data, b_data;
    logic        fb_wr_en;
    logic [10:0] fb_wr_addr;
    logic [5:0]  fb_wr_data;
    logic        disp_valid;
    logic [10:0] disp_addr;
    logic        host_rd_req, host_rd_gnt, host_rd_valid;
    logic [10:0] host_rd_addr;
    logic [5:0]  host_rd_data;
    logic [10:0] fb_rd_addr;
    logic [5:0]  fb_rd_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    big_fb_ctrl #(.ADDR_W(11), .DATA_W(6)) dut (
        .clk(clk), .rst(rst),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .disp_valid(disp_valid), .disp_addr(disp_addr),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_gnt(host_rd_gnt), .host_rd_valid(host_rd_valid),
        .host_rd_data(host_rd_data),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data)
    );

    // One-cycle-latency RAM model behind the controller.
    logic [5:0] mem [2048];
    always @(posedge clk) begin
        if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
        fb_rd_data <= mem[fb_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        a_req, b_req;
        logic [10:0] a_addr, b_addr;
        logic [5:0]  a_data, b_data;
        int          winner;  // 0 none, 1 A, 2 B
    } vec_t;

    vec_t vecs [10];

    initial begin
        int busy_cycles;
        int ferr;
        logic [10:0] exp_addr;
        logic [5:0]  exp_data;

        // Hand-computed winners, starting from the "B last" reset pointer.
        vecs[0] = '{1'b1, 1'b1, 11'h010, 11'h020, 6'h01, 6'h30, 1};
        vecs[1] = '{1'b1, 1'b1, 11'h011, 11'h021, 6'h02, 6'h31, 2};
        vecs[2] = '{1'b1, 1'b1, 11'h012, 11'h022, 6'h03, 6'h32, 1};
        vecs[3] = '{1'b1, 1'b1, 11'h013, 11'h023, 6'h04, 6'h33, 2};
        vecs[4] = '{1'b0, 1'b0, 11'h014, 11'h024, 6'h05, 6'h34, 0};
        vecs[5] = '{1'b0, 1'b1, 11'h015, 11'h025, 6'h06, 6'h35, 2};
        vecs[6] = '{1'b0, 1'b1, 11'h016, 11'h026, 6'h07, 6'h36, 2};
        vecs[7] = '{1'b1, 1'b1, 11'h017, 11'h027, 6'h08, 6'h37, 1};
        vecs[8] = '{1'b1, 1'b0, 11'h018, 11'h028, 6'h09, 6'h38, 1};
        vecs[9] = '{1'b1, 1'b1, 11'h019, 11'h029, 6'h0A, 6'h39, 2};

        rst = 1'b1; fill_start = 1'b1; fill_data = 6'h3F;
        a_req = 1'b1; b_req = 1'b1; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        disp_valid = 1'b0; disp_addr = '0; host_rd_req = 1'b1; host_rd_addr = '0;

        // Reset: combinational grants suppressed, registers cleared.
        tick(); tick();
        #2;
        chk("rst_a_gnt", 32'(a_gnt), 0);
        chk("rst_b_gnt", 32'(b_gnt), 0);
        chk("rst_host_gnt", 32'(host_rd_gnt), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_wr_en", 32'(fb_wr_en), 0);
        chk("rst_rd_valid", 32'(host_rd_valid), 0);
        chk("rst_wr_addr", 32'(fb_wr_addr), 0);
        chk("rst_wr_data", 32'(fb_wr_data), 0);
        chk("rst_rd_data", 32'(host_rd_data), 0);
        fill_start = 1'b0; a_req = 1'b0; b_req = 1'b0; host_rd_req = 1'b0;
        tick();
        rst = 1'b0;

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            a_req = vecs[i].a_req; b_req = vecs[i].b_req;
            a_addr = vecs[i].a_addr; b_addr = vecs[i].b_addr;
            a_data = vecs[i].a_data; b_data = vecs[i].b_data;
            #2;
            chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].winner == 1));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].winner == 2));
            tick();
            chk($sformatf("v%0d_wr_en", i), 32'(fb_wr_en), 32'(vecs[i].winner != 0));
            if (vecs[i].winner != 0) begin
                exp_addr = (vecs[i].winner == 1) ? vecs[i].a_addr : vecs[i].b_addr;
                exp_data = (vecs[i].winner == 1) ? vecs[i].a_data : vecs[i].b_data;
                chk($sformatf("v%0d_wr_addr", i), 32'(fb_wr_addr), 32'(exp_addr));
                chk($sformatf("v%0d_wr_data", i), 32'(fb_wr_data), 32'(exp_data));
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Write 0x15 to 0x123, then host read it back.
        a_req = 1'b1; a_addr = 11'h123; a_data = 6'h15;
        #2;
        chk("hw_a_gnt", 32'(a_gnt), 1);
        tick();
        a_req = 1'b0;
        tick();
        host_rd_req = 1'b1; host_rd_addr = 11'h123;
        #2;
        chk("hr_gnt", 32'(host_rd_gnt), 1);
        chk("hr_rd_addr", 32'(fb_rd_addr), 32'h123);
        tick();
        host_rd_req = 1'b0;
        chk("hr_valid_n1", 32'(host_rd_valid), 0);
        tick();
        chk("hr_valid_n2", 32'(host_rd_valid), 1);
        chk("hr_data", 32'(host_rd_data), 32'h15);
        tick();
        chk("hr_valid_n3", 32'(host_rd_valid), 0);

        // Display priority for three cycles, then host grant when it drops.
        host_rd_req = 1'b1; host_rd_addr = 11'h2F0; disp_valid = 1'b1; disp_addr = 11'h055;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("dp%0d_host_gnt", i), 32'(host_rd_gnt), 0);
            chk($sformatf("dp%0d_rd_addr", i), 32'(fb_rd_addr), 32'h055);
            tick();
        end
        disp_valid = 1'b0;
        #2;
        chk("dp_host_gnt", 32'(host_rd_gnt), 1);
        chk("dp_rd_addr", 32'(fb_rd_addr), 32'h2F0);
        tick();
        host_rd_req = 1'b0;
        tick();
        chk("dp_valid", 32'(host_rd_valid), 1);
        tick();

        // fill_start together with a_req: no grant, then a full fill.
        fill_start = 1'b1; fill_data = 6'h2A;
        a_req = 1'b1; a_addr = 11'h007; a_data = 6'h09;
        #2;
        chk("fs_a_gnt", 32'(a_gnt), 0);
        chk("fs_busy", 32'(fill_busy), 0);
        tick();
        fill_start = 1'b0; fill_data = 6'h00;
        busy_cycles = 0; ferr = 0;
        while (fill_busy && busy_cycles < 3000) begin
            if (a_gnt !== 1'b0) ferr++;
            if (busy_cycles == 0) begin
                if (fb_wr_en !== 1'b0) ferr++;
            end else if (fb_wr_en !== 1'b1 || fb_wr_addr !== 11'(busy_cycles - 1)
                         || fb_wr_data !== 6'h2A) begin
                ferr++;
            end
            busy_cycles++;
            tick();
        end
        chk("fill_writes", 32'(ferr), 0);
        chk("fill_len", 32'(busy_cycles), 2048);
        chk("fill_done", 32'(fill_done), 1);
        chk("fill_last_en", 32'(fb_wr_en), 1);
        chk("fill_last_addr", 32'(fb_wr_addr), 32'h7FF);
        chk("fill_last_data", 32'(fb_wr_data), 32'h2A);
        chk("fill_mem_mid", 32'(mem[11'h400]), 32'h2A);
        #2;
        chk("post_fill_a_gnt", 32'(a_gnt), 1);
        tick();
        a_req = 1'b0;
        chk("fill_done_pulse", 32'(fill_done), 0);
        chk("post_fill_wr_addr", 32'(fb_wr_addr), 32'h007);
        chk("post_fill_wr_data", 32'(fb_wr_data), 32'h09);
        tick();

        // Reset at counter 100 with a host read in flight.
        fill_start = 1'b1; fill_data = 6'h11;
        tick();
        fill_start = 1'b0;
        repeat (99) tick();
        host_rd_req = 1'b1; host_rd_addr = 11'h005;
        #2;
        chk("mf_host_gnt", 32'(host_rd_gnt), 1);
        tick();
        host_rd_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mf_busy", 32'(fill_busy), 0);
        chk("mf_done", 32'(fill_done), 0);
        chk("mf_wr_en", 32'(fb_wr_en), 0);
        chk("mf_rd_valid", 32'(host_rd_valid), 0);
        tick();
        chk("mf_done2", 32'(fill_done), 0);
        chk("mf_rd_valid2", 32'(host_rd_valid), 0);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        chk("rf_busy", 32'(fill_busy), 1);
        chk("rf_wr_en0", 32'(fb_wr_en), 0);
        tick();
        chk("rf_wr_en1", 32'(fb_wr_en), 1);
        chk("rf_wr_addr0", 32'(fb_wr_addr), 32'h000);
        chk("rf_wr_data0", 32'(fb_wr_data), 32'h11);
        tick();
        chk("rf_wr_addr1", 32'(fb_wr_addr), 32'h001);
        rst = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
